// File: rtl/bp_lite_to_stream_buffered_pkg.sv
// Shared BedRock message types, address-mode encoding and beat-count helper
// for the buffered Lite-to-Stream converter.
package bp_lite_to_stream_buffered_pkg;

  localparam int paddr_width_gp   = 40;
  localparam int payload_width_gp = 1;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  typedef enum logic {
    e_addr_linear = 1'b0,
    e_addr_wrap   = 1'b1
  } bp_addr_mode_e;

  // Messages without data, or smaller than one beat, still occupy one beat.
  function automatic logic [7:0] beats_f(input bp_bedrock_msg_size_e size,
                                         input logic has_data,
                                         input int unsigned out_bytes);
    int unsigned n;
    n = (32'd1 << size) / out_bytes;
    if (!has_data || n == 0) n = 1;
    return 8'(n);
  endfunction

endpackage

// File: rtl/bp_lite_to_stream_buffered_if.sv
// Lite input and Stream output bundle; signal names are from the converter's side.
interface bp_lite_to_stream_buffered_if
  import bp_lite_to_stream_buffered_pkg::*;
#(
  parameter int in_data_width_p  = 512,
  parameter int out_data_width_p = 64
) ();

  bp_bedrock_mem_header_s      in_msg_header_i;
  logic [in_data_width_p-1:0]  in_msg_data_i;
  logic                        in_msg_v_i;
  logic                        in_msg_ready_and_o;
  bp_bedrock_mem_header_s      out_msg_header_o;
  logic [out_data_width_p-1:0] out_msg_data_o;
  logic                        out_msg_v_o;
  logic                        out_msg_ready_and_i;
  logic                        out_msg_last_o;

  modport slave (
    input  in_msg_header_i, in_msg_data_i, in_msg_v_i, out_msg_ready_and_i,
    output in_msg_ready_and_o, out_msg_header_o, out_msg_data_o, out_msg_v_o,
           out_msg_last_o
  );

  modport master (
    output in_msg_header_i, in_msg_data_i, in_msg_v_i, out_msg_ready_and_i,
    input  in_msg_ready_and_o, out_msg_header_o, out_msg_data_o, out_msg_v_o,
           out_msg_last_o
  );

endinterface

// File: rtl/bp_lite_to_stream_buffered_beat_gen.sv
// Per-beat counter and address generator for one BedRock stream message;
// shared by both conversion directions.
module bp_lite_to_stream_buffered_beat_gen
  import bp_lite_to_stream_buffered_pkg::*;
#(
  parameter int            out_data_width_p = 64,
  parameter int            stream_words_p   = 8,
  parameter int unsigned   payload_mask_p   = 0,
  parameter bp_addr_mode_e wrap_mode_p      = e_addr_wrap,
  localparam int           len_w_lp         = (stream_words_p > 1) ? $clog2(stream_words_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic                       ready_and_i,
  input  bp_bedrock_mem_type_e       msg_type_i,
  input  bp_bedrock_msg_size_e       size_i,
  input  logic [paddr_width_gp-1:0]  addr_i,
  output logic [len_w_lp-1:0]        word_o,
  output logic [paddr_width_gp-1:0]  addr_o,
  output logic                       last_o,
  output logic                       done_o
);

  localparam int          off_w_lp = $clog2(out_data_width_p / 8);
  localparam logic [15:0] mask_lp  = 16'(payload_mask_p);

  logic [7:0]          k_q, k_d, beats;
  logic [len_w_lp-1:0] first, idx;
  logic [8:0]          sum;

  assign beats  = beats_f(size_i, mask_lp[msg_type_i], out_data_width_p / 8);
  assign first  = addr_i[off_w_lp +: len_w_lp];
  assign sum    = 9'(first) + 9'(k_q);
  assign idx    = (wrap_mode_p == e_addr_wrap) ? len_w_lp'(sum % 9'(stream_words_p))
                                               : len_w_lp'(sum);
  assign word_o = len_w_lp'(k_q);
  assign addr_o = {addr_i[paddr_width_gp-1:off_w_lp+len_w_lp], idx, addr_i[off_w_lp-1:0]};
  assign last_o = v_i & (k_q == beats - 8'd1);
  assign done_o = last_o & ready_and_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    k_d = k_q;
    if (v_i && ready_and_i) k_d = last_o ? '0 : k_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) k_q <= '0;
    else         k_q <= k_d;
  end

  // A linear stream must not run past the end of the data block.
  always_ff @(posedge clk_i) begin
    if (!reset_i && v_i && wrap_mode_p == e_addr_linear)
      assert (int'(first) + int'(beats) <= stream_words_p)
        else $error("linear stream overflows the data block");
  end

endmodule

// File: rtl/bp_lite_to_stream_buffered.sv
// Buffered BedRock Lite to Stream converter: a small registered FIFO of Lite
// messages drained one narrow beat at a time, with back-to-back streams.
module bp_lite_to_stream_buffered
  import bp_lite_to_stream_buffered_pkg::*;
#(
  parameter int            in_data_width_p  = 512,
  parameter int            out_data_width_p = 64,
  parameter int            payload_width_p  = 1,
  parameter int unsigned   payload_mask_p   = 0,
  parameter int            buffer_els_p     = 2,
  parameter bp_addr_mode_e wrap_mode_p      = e_addr_wrap
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  bp_lite_to_stream_buffered_if.slave msg_if
);

  localparam int stream_words_lp = in_data_width_p / out_data_width_p;
  localparam int len_w_lp        = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;
  localparam int ptr_w_lp        = (buffer_els_p > 1) ? $clog2(buffer_els_p) : 1;
  localparam int cnt_w_lp        = $clog2(buffer_els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(buffer_els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(buffer_els_p);

  if (in_data_width_p < out_data_width_p) begin : g_err_narrow
    $error("in_data_width_p must be at least out_data_width_p");
  end
  if (in_data_width_p % out_data_width_p != 0) begin : g_err_ratio
    $error("in_data_width_p must be a multiple of out_data_width_p");
  end
  if (buffer_els_p < 1) begin : g_err_depth
    $error("buffer_els_p must be at least 1");
  end
  if (payload_width_p != payload_width_gp) begin : g_err_payload
    $error("payload_width_p must match the packaged header payload width");
  end

  bp_bedrock_mem_header_s     hdr_mem_q  [buffer_els_p];
  logic [in_data_width_p-1:0] data_mem_q [buffer_els_p];
  logic [ptr_w_lp-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic                       push, pop, full, empty;

  bp_bedrock_mem_header_s                           head_hdr;
  logic [stream_words_lp-1:0][out_data_width_p-1:0] head_words;
  logic [len_w_lp-1:0]                              word_idx;
  logic [paddr_width_gp-1:0]                        beat_addr;
  logic                                             beat_last;

  assign full  = (cnt_q == full_cnt_lp);
  assign empty = (cnt_q == '0);
  assign push  = msg_if.in_msg_v_i & ~full;
  assign msg_if.in_msg_ready_and_o = ~full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy count alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      hdr_mem_q[wr_ptr_q]  <= msg_if.in_msg_header_i;
      data_mem_q[wr_ptr_q] <= msg_if.in_msg_data_i;
    end
  end

  assign head_hdr   = hdr_mem_q[rd_ptr_q];
  assign head_words = data_mem_q[rd_ptr_q];

  bp_lite_to_stream_buffered_beat_gen #(
    .out_data_width_p (out_data_width_p),
    .stream_words_p   (stream_words_lp),
    .payload_mask_p   (payload_mask_p),
    .wrap_mode_p      (wrap_mode_p)
  ) u_beat_gen (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (~empty),
    .ready_and_i (msg_if.out_msg_ready_and_i),
    .msg_type_i  (head_hdr.msg_type),
    .size_i      (head_hdr.size),
    .addr_i      (head_hdr.addr),
    .word_o      (word_idx),
    .addr_o      (beat_addr),
    .last_o      (beat_last),
    .done_o      (pop)
  );

  always_comb begin
    msg_if.out_msg_header_o      = head_hdr;
    msg_if.out_msg_header_o.addr = beat_addr;
  end

  assign msg_if.out_msg_data_o = head_words[word_idx];
  assign msg_if.out_msg_v_o    = ~empty;
  assign msg_if.out_msg_last_o = beat_last;

endmodule

// File: tb/tb_bp_lite_to_stream_buffered.sv
// Bench for bp_lite_to_stream_buffered: a wrap-mode and a linear-mode instance,
// directed vector table, hand-written corner sequences and a random scoreboard run.
module tb_bp_lite_to_stream_buffered;
  import bp_lite_to_stream_buffered_pkg::*;

  typedef bp_bedrock_mem_header_s hdr_s;

  localparam logic [15:0] mask_lp = 16'b0000_0000_0000_1010;  // wr and uc_wr carry data

  logic         clk = 1'b0;
  logic         reset;
  logic         sel;      // 0 = wrap instance, 1 = linear instance
  logic         in_v;
  hdr_s         in_hdr;
  logic [511:0] in_data;
  logic         out_rdy;

  always #5 clk = ~clk;

  bp_lite_to_stream_buffered_if #(.in_data_width_p(512), .out_data_width_p(64)) if_w ();
  bp_lite_to_stream_buffered_if #(.in_data_width_p(512), .out_data_width_p(64)) if_l ();

  assign if_w.in_msg_header_i     = in_hdr;
  assign if_w.in_msg_data_i       = in_data;
  assign if_w.in_msg_v_i          = in_v & ~sel;
  assign if_w.out_msg_ready_and_i = out_rdy;
  assign if_l.in_msg_header_i     = in_hdr;
  assign if_l.in_msg_data_i       = in_data;
  assign if_l.in_msg_v_i          = in_v & sel;
  assign if_l.out_msg_ready_and_i = out_rdy;

  bp_lite_to_stream_buffered #(
    .in_data_width_p(512), .out_data_width_p(64), .payload_width_p(1),
    .payload_mask_p(32'(mask_lp)), .buffer_els_p(2), .wrap_mode_p(e_addr_wrap)
  ) dut_w (.clk_i(clk), .reset_i(reset), .msg_if(if_w));

  bp_lite_to_stream_buffered #(
    .in_data_width_p(512), .out_data_width_p(64), .payload_width_p(1),
    .payload_mask_p(32'(mask_lp)), .buffer_els_p(2), .wrap_mode_p(e_addr_linear)
  ) dut_l (.clk_i(clk), .reset_i(reset), .msg_if(if_l));

  logic        mon_in_ready, mon_out_v, mon_last;
  hdr_s        mon_hdr;
  logic [63:0] mon_data;
  assign mon_in_ready = sel ? if_l.in_msg_ready_and_o : if_w.in_msg_ready_and_o;
  assign mon_out_v    = sel ? if_l.out_msg_v_o        : if_w.out_msg_v_o;
  assign mon_last     = sel ? if_l.out_msg_last_o     : if_w.out_msg_last_o;
  assign mon_hdr      = sel ? if_l.out_msg_header_o   : if_w.out_msg_header_o;
  assign mon_data     = sel ? if_l.out_msg_data_o     : if_w.out_msg_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of expected beats plus a count of buffered messages.
  typedef struct {
    hdr_s        hdr;
    logic [39:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    msg_cnt = 0;

  function automatic int n_beats(input hdr_s h);
    int n;
    if (!mask_lp[h.msg_type]) return 1;
    n = (1 << h.size) / 8;
    return (n < 1) ? 1 : n;
  endfunction

  task automatic model_push(input hdr_s h, input logic [511:0] d);
    int first, n;
    first = int'((h.addr / 40'd8) % 40'd8);
    n     = n_beats(h);
    for (int k = 0; k < n; k++) begin
      int           idx;
      logic [511:0] sh;
      beat_t        b;
      idx    = sel ? first + k : (first + k) % 8;
      b.hdr  = h;
      b.addr = h.addr - 40'(first * 8) + 40'(idx * 8);
      sh     = d >> (64 * k);
      b.data = sh[63:0];
      b.last = (k == n - 1);
      exp_q.push_back(b);
    end
    msg_cnt++;
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic v, input hdr_s h, input logic [511:0] d, input logic rdy,
                      output logic acc, output logic hs, output logic hl);
    @(posedge clk);
    #1;
    in_v = v; in_hdr = h; in_data = d; out_rdy = rdy;
    #3;
    check("in_ready", mon_in_ready, msg_cnt < 2);
    check("out_v", mon_out_v, msg_cnt > 0);
    if (msg_cnt > 0) begin
      check("beat_addr", mon_hdr.addr, exp_q[0].addr);
      check("beat_type", mon_hdr.msg_type, exp_q[0].hdr.msg_type);
      check("beat_size", mon_hdr.size, exp_q[0].hdr.size);
      check("beat_payload", mon_hdr.payload, exp_q[0].hdr.payload);
      check("beat_data", mon_data, exp_q[0].data);
      check("beat_last", mon_last, exp_q[0].last);
    end else begin
      check("idle_last", mon_last, 1'b0);
    end
    acc = v && (msg_cnt < 2);
    hs  = (msg_cnt > 0) && rdy;
    hl  = 1'b0;
    if (hs) begin
      hl = exp_q[0].last;
      void'(exp_q.pop_front());
      if (hl) msg_cnt--;
    end
    if (acc) model_push(h, d);
  endtask

  function automatic hdr_s mk_hdr(input bp_bedrock_mem_type_e t, input bp_bedrock_msg_size_e s,
                                  input logic [39:0] a, input logic p);
    hdr_s h;
    h.msg_type = t; h.size = s; h.addr = a; h.payload = p;
    return h;
  endfunction

  function automatic logic [63:0] word_pat(input int v, input int i);
    return {16'hDA7A, 16'(v), 32'(i)};
  endfunction

  function automatic logic [511:0] pat_data(input int v);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[64*i +: 64] = word_pat(v, i);
    return d;
  endfunction

  task automatic drain(input string name);
    logic acc, hs, hl;
    int   c;
    for (c = 0; c < 200 && msg_cnt > 0; c++) step(1'b0, in_hdr, in_data, 1'b1, acc, hs, hl);
    if (msg_cnt > 0) check(name, 32'(msg_cnt), 32'd0);
  endtask

  typedef struct {
    hdr_s             hdr;
    logic             lin;
    int               n;
    logic [7:0][39:0] addrs;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, hs, hl, prev_hl;
    int   cnt;

    reset = 1'b1; sel = 1'b0; in_v = 1'b0; out_rdy = 1'b0; in_hdr = '0; in_data = '0;

    // Directed vectors with hand-derived beat addresses.
    vecs[0].hdr = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80000010, 1'b1);
    vecs[0].lin = 1'b0; vecs[0].n = 8;
    vecs[0].addrs[0] = 40'h80000010; vecs[0].addrs[1] = 40'h80000018;
    vecs[0].addrs[2] = 40'h80000020; vecs[0].addrs[3] = 40'h80000028;
    vecs[0].addrs[4] = 40'h80000030; vecs[0].addrs[5] = 40'h80000038;
    vecs[0].addrs[6] = 40'h80000000; vecs[0].addrs[7] = 40'h80000008;
    vecs[1].hdr = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_2, 40'h80000006, 1'b0);
    vecs[1].lin = 1'b0; vecs[1].n = 1; vecs[1].addrs = '0; vecs[1].addrs[0] = 40'h80000006;
    vecs[2].hdr = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80000010, 1'b1);
    vecs[2].lin = 1'b0; vecs[2].n = 1; vecs[2].addrs = '0; vecs[2].addrs[0] = 40'h80000010;
    vecs[3].hdr = mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_16, 40'h80000038, 1'b0);
    vecs[3].lin = 1'b0; vecs[3].n = 2; vecs[3].addrs = '0;
    vecs[3].addrs[0] = 40'h80000038; vecs[3].addrs[1] = 40'h80000000;
    vecs[4].hdr = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h8000002C, 1'b1);
    vecs[4].lin = 1'b0; vecs[4].n = 1; vecs[4].addrs = '0; vecs[4].addrs[0] = 40'h8000002C;
    vecs[5].hdr = mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_16, 40'h0000000030, 1'b0);
    vecs[5].lin = 1'b1; vecs[5].n = 2; vecs[5].addrs = '0;
    vecs[5].addrs[0] = 40'h30; vecs[5].addrs[1] = 40'h38;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #3;
    check("rst_in_ready_w", if_w.in_msg_ready_and_o, 1'b1);
    check("rst_out_v_w", if_w.out_msg_v_o, 1'b0);
    check("rst_last_w", if_w.out_msg_last_o, 1'b0);
    check("rst_in_ready_l", if_l.in_msg_ready_and_o, 1'b1);
    check("rst_out_v_l", if_l.out_msg_v_o, 1'b0);
    check("rst_last_l", if_l.out_msg_last_o, 1'b0);

    // Table-driven single messages, full-rate sink.
    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].lin;
      step(1'b1, vecs[v].hdr, pat_data(v), 1'b1, acc, hs, hl);
      for (int b = 0; b < vecs[v].n; b++) begin
        step(1'b0, vecs[v].hdr, pat_data(v), 1'b1, acc, hs, hl);
        check("vec_v", mon_out_v, 1'b1);
        check("vec_addr", mon_hdr.addr, vecs[v].addrs[b]);
        check("vec_size", mon_hdr.size, vecs[v].hdr.size);
        check("vec_data", mon_data, word_pat(v, b));
        check("vec_last", mon_last, b == vecs[v].n - 1);
      end
      step(1'b0, vecs[v].hdr, pat_data(v), 1'b1, acc, hs, hl);
      check("vec_done_v", mon_out_v, 1'b0);
    end
    sel = 1'b0;

    // Random backpressure on the 64B wrap message.
    step(1'b1, vecs[0].hdr, pat_data(0), 1'b0, acc, hs, hl);
    cnt = 0; hl = 1'b0;
    for (int c = 0; c < 200 && !hl; c++) begin
      step(1'b0, vecs[0].hdr, pat_data(0), 1'($urandom_range(0, 1)), acc, hs, hl);
      if (hs) cnt++;
    end
    check("bp_beats", cnt, 8);
    step(1'b0, vecs[0].hdr, pat_data(0), 1'b1, acc, hs, hl);
    check("bp_empty", mon_out_v, 1'b0);

    // Back-to-back streams and a third message held off by a full buffer.
    step(1'b1, mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80000000, 1'b0), pat_data(10), 1'b1, acc, hs, hl);
    check("b2b_ready1", mon_in_ready, 1'b1);
    step(1'b1, mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80001000, 1'b1), pat_data(11), 1'b1, acc, hs, hl);
    check("b2b_ready2", mon_in_ready, 1'b1);
    prev_hl = 1'b0; cnt = 0; acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      step(1'b1, mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_32, 40'h80002018, 1'b0), pat_data(12), 1'b1, acc, hs, hl);
      if (prev_hl) begin
        check("b2b_no_bubble", mon_out_v, 1'b1);
        check("b2b_beat0_addr", mon_hdr.addr, 40'h80001000);
        check("b2b_beat0_data", mon_data, word_pat(11, 0));
        check("b2b_ready_rise", mon_in_ready, 1'b1);
      end
      prev_hl = hl;
      if (!acc) cnt++;
    end
    check("b2b_wait_cycles", cnt, 7);
    drain("b2b_drain");
    step(1'b0, in_hdr, in_data, 1'b1, acc, hs, hl);

    // Random traffic against the scoreboard (wrap instance).
    for (int c = 0; c < 400; c++) begin
      hdr_s         h;
      logic [511:0] d;
      h = mk_hdr(bp_bedrock_mem_type_e'($urandom_range(0, 5)),
                 bp_bedrock_msg_size_e'($urandom_range(0, 6)),
                 {8'($urandom), 32'($urandom)}, 1'($urandom));
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      step(1'($urandom_range(0, 9) < 6), h, d, 1'($urandom_range(0, 1)), acc, hs, hl);
    end
    drain("rand_drain");

    // Linear mode, then reset in the middle of the second message.
    sel = 1'b1;
    step(1'b1, mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_16, 40'h30, 1'b0), pat_data(20), 1'b0, acc, hs, hl);
    step(1'b1, mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80000100, 1'b1), pat_data(21), 1'b0, acc, hs, hl);
    step(1'b0, in_hdr, in_data, 1'b1, acc, hs, hl);
    check("lin_beat0", mon_hdr.addr, 40'h30);
    step(1'b0, in_hdr, in_data, 1'b1, acc, hs, hl);
    check("lin_beat1", mon_hdr.addr, 40'h38);
    step(1'b1, mk_hdr(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h80000208, 1'b0), pat_data(22), 1'b1, acc, hs, hl);
    step(1'b0, in_hdr, in_data, 1'b0, acc, hs, hl);
    check("lin_m2_beat1", mon_hdr.addr, 40'h80000108);
    @(posedge clk);
    #1 reset = 1'b1; in_v = 1'b0; out_rdy = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #3;
    check("midrst_out_v", mon_out_v, 1'b0);
    check("midrst_last", mon_last, 1'b0);
    check("midrst_in_ready", mon_in_ready, 1'b1);
    exp_q.delete();
    msg_cnt = 0;
    for (int c = 0; c < 4; c++) step(1'b0, in_hdr, in_data, 1'b1, acc, hs, hl);
    step(1'b1, mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_16, 40'h80000420, 1'b1), pat_data(23), 1'b1, acc, hs, hl);
    drain("post_rst_drain");
    step(1'b0, in_hdr, in_data, 1'b1, acc, hs, hl);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
